// File: rtl/riscv_axi_arb_pkg.sv
// rtl/riscv_axi_arb_pkg.sv - shared FSM encodings and AXI response codes for the 2:1 AXI arbiter
package riscv_axi_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

endpackage

// File: rtl/riscv_axi_arb_rr2.sv
// rtl/riscv_axi_arb_rr2.sv - combinational 2-way round-robin picker
module riscv_axi_arb_rr2
  import riscv_axi_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o
);

  // A lone requester wins outright; on a tie the master not granted last time wins
  always_comb begin
    grant_o = 1'b0;
    case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_grant_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_axi_arb2.sv
// rtl/riscv_axi_arb2.sv - 2-master (icache/dcache) to 1-slave AXI4 arbiter; RISCV_AXI_ARB_FIXED_PRIO_EN gives dcache fixed priority
module riscv_axi_arb2
  import riscv_axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // master side read address
  input  logic [1:0]              m_axi_arvalid_i,
  input  logic [2*ADDR_W-1:0]     m_axi_araddr_i,
  input  logic [2*ID_W-1:0]       m_axi_arid_i,
  input  logic [15:0]             m_axi_arlen_i,
  input  logic [3:0]              m_axi_arburst_i,
  output logic [1:0]              m_axi_arready_o,
  // master side read data
  output logic [1:0]              m_axi_rvalid_o,
  output logic [2*DATA_W-1:0]     m_axi_rdata_o,
  output logic [3:0]              m_axi_rresp_o,
  output logic [2*ID_W-1:0]       m_axi_rid_o,
  output logic [1:0]              m_axi_rlast_o,
  input  logic [1:0]              m_axi_rready_i,
  // master side write address
  input  logic [1:0]              m_axi_awvalid_i,
  input  logic [2*ADDR_W-1:0]     m_axi_awaddr_i,
  input  logic [2*ID_W-1:0]       m_axi_awid_i,
  input  logic [15:0]             m_axi_awlen_i,
  input  logic [3:0]              m_axi_awburst_i,
  output logic [1:0]              m_axi_awready_o,
  // master side write data
  input  logic [1:0]              m_axi_wvalid_i,
  input  logic [2*DATA_W-1:0]     m_axi_wdata_i,
  input  logic [2*(DATA_W/8)-1:0] m_axi_wstrb_i,
  input  logic [1:0]              m_axi_wlast_i,
  output logic [1:0]              m_axi_wready_o,
  // master side write response
  output logic [1:0]              m_axi_bvalid_o,
  output logic [3:0]              m_axi_bresp_o,
  output logic [2*ID_W-1:0]       m_axi_bid_o,
  input  logic [1:0]              m_axi_bready_i,
  // slave side read address
  output logic                    s_axi_arvalid_o,
  output logic [ADDR_W-1:0]       s_axi_araddr_o,
  output logic [ID_W-1:0]         s_axi_arid_o,
  output logic [7:0]              s_axi_arlen_o,
  output logic [1:0]              s_axi_arburst_o,
  input  logic                    s_axi_arready_i,
  // slave side read data
  input  logic                    s_axi_rvalid_i,
  input  logic [DATA_W-1:0]       s_axi_rdata_i,
  input  logic [1:0]              s_axi_rresp_i,
  input  logic [ID_W-1:0]         s_axi_rid_i,
  input  logic                    s_axi_rlast_i,
  output logic                    s_axi_rready_o,
  // slave side write address
  output logic                    s_axi_awvalid_o,
  output logic [ADDR_W-1:0]       s_axi_awaddr_o,
  output logic [ID_W-1:0]         s_axi_awid_o,
  output logic [7:0]              s_axi_awlen_o,
  output logic [1:0]              s_axi_awburst_o,
  input  logic                    s_axi_awready_i,
  // slave side write data
  output logic                    s_axi_wvalid_o,
  output logic [DATA_W-1:0]       s_axi_wdata_o,
  output logic [(DATA_W/8)-1:0]   s_axi_wstrb_o,
  output logic                    s_axi_wlast_o,
  input  logic                    s_axi_wready_i,
  // slave side write response
  input  logic                    s_axi_bvalid_i,
  input  logic [1:0]              s_axi_bresp_i,
  input  logic [ID_W-1:0]         s_axi_bid_i,
  output logic                    s_axi_bready_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  rd_state_e   rd_state_q;
  logic        rd_owner_q;
  wr_state_e   wr_state_q;
  logic        wr_owner_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        aw_done_d;
  logic        w_done_d;

  logic        rd_pick;
  logic        wr_pick;
  logic        rd_last_grant;
  logic        wr_last_grant;

  logic [31:0] rd_sel;
  logic [31:0] wr_sel;

  logic        ar_hs;
  logic        r_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;

  assign rd_sel = {31'd0, rd_owner_q};
  assign wr_sel = {31'd0, wr_owner_q};

  // Slave-side valids are zero outside their owning state, so these are state-qualified
  assign ar_hs = s_axi_arvalid_o & s_axi_arready_i;
  assign r_hs  = s_axi_rvalid_i  & s_axi_rready_o;
  assign aw_hs = s_axi_awvalid_o & s_axi_awready_i;
  assign w_hs  = s_axi_wvalid_o  & s_axi_wready_i;
  assign b_hs  = s_axi_bvalid_i  & s_axi_bready_o;

  assign aw_done_d = aw_done_q | aw_hs;
  assign w_done_d  = w_done_q  | (w_hs & s_axi_wlast_o);

`ifdef RISCV_AXI_ARB_FIXED_PRIO_EN
  // Pretending master 0 was always granted last makes the picker hand every tie to the dcache
  assign rd_last_grant = 1'b0;
  assign wr_last_grant = 1'b0;
`else
  logic rd_ptr_q;
  logic wr_ptr_q;

  // Last-grant pointers move only when a burst's address is actually accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= 1'b1;
      wr_ptr_q <= 1'b1;
    end else begin
      if (ar_hs) rd_ptr_q <= rd_owner_q;
      if (aw_hs) wr_ptr_q <= wr_owner_q;
    end
  end

  assign rd_last_grant = rd_ptr_q;
  assign wr_last_grant = wr_ptr_q;
`endif

  riscv_axi_arb_rr2 u_rd_pick (
    .req_i        (m_axi_arvalid_i),
    .last_grant_i (rd_last_grant),
    .grant_o      (rd_pick)
  );

  riscv_axi_arb_rr2 u_wr_pick (
    .req_i        (m_axi_awvalid_i),
    .last_grant_i (wr_last_grant),
    .grant_o      (wr_pick)
  );

  // Read path FSM: latch owner, pass one AR, then stream R until rlast
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      rd_owner_q <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (|m_axi_arvalid_i) begin
            rd_owner_q <= rd_pick;
            rd_state_q <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (ar_hs) rd_state_q <= R_DATA;
        end
        R_DATA: begin
          if (r_hs && s_axi_rlast_i) rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // Write path FSM: AW and W of the owner run concurrently with sticky completion flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      wr_owner_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (|m_axi_awvalid_i) begin
            wr_owner_q <= wr_pick;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wr_state_q <= W_XFER;
          end
        end
        W_XFER: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) wr_state_q <= W_RESP;
        end
        W_RESP: begin
          if (b_hs) wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Read routing: everything keyed off the registered owner, zero elsewhere
  always_comb begin
    s_axi_arvalid_o = 1'b0;
    s_axi_araddr_o  = '0;
    s_axi_arid_o    = '0;
    s_axi_arlen_o   = '0;
    s_axi_arburst_o = '0;
    m_axi_arready_o = '0;
    m_axi_rvalid_o  = '0;
    m_axi_rdata_o   = '0;
    m_axi_rresp_o   = '0;
    m_axi_rid_o     = '0;
    m_axi_rlast_o   = '0;
    s_axi_rready_o  = 1'b0;
    if (rd_state_q == R_ADDR) begin
      s_axi_arvalid_o             = m_axi_arvalid_i[rd_owner_q];
      s_axi_araddr_o              = m_axi_araddr_i[rd_sel*ADDR_W +: ADDR_W];
      s_axi_arid_o                = m_axi_arid_i[rd_sel*ID_W +: ID_W];
      s_axi_arlen_o               = m_axi_arlen_i[rd_sel*8 +: 8];
      s_axi_arburst_o             = m_axi_arburst_i[rd_sel*2 +: 2];
      m_axi_arready_o[rd_owner_q] = s_axi_arready_i;
    end
    if (rd_state_q == R_DATA) begin
      m_axi_rvalid_o[rd_owner_q]               = s_axi_rvalid_i;
      m_axi_rdata_o[rd_sel*DATA_W +: DATA_W]   = s_axi_rdata_i;
      m_axi_rresp_o[rd_sel*2 +: 2]             = s_axi_rresp_i;
      m_axi_rid_o[rd_sel*ID_W +: ID_W]         = s_axi_rid_i;
      m_axi_rlast_o[rd_owner_q]                = s_axi_rlast_i;
      s_axi_rready_o                           = m_axi_rready_i[rd_owner_q];
    end
  end

  // Write routing: AW/W gated by their done flags so neither channel repeats
  always_comb begin
    s_axi_awvalid_o = 1'b0;
    s_axi_awaddr_o  = '0;
    s_axi_awid_o    = '0;
    s_axi_awlen_o   = '0;
    s_axi_awburst_o = '0;
    m_axi_awready_o = '0;
    s_axi_wvalid_o  = 1'b0;
    s_axi_wdata_o   = '0;
    s_axi_wstrb_o   = '0;
    s_axi_wlast_o   = 1'b0;
    m_axi_wready_o  = '0;
    m_axi_bvalid_o  = '0;
    m_axi_bresp_o   = '0;
    m_axi_bid_o     = '0;
    s_axi_bready_o  = 1'b0;
    if (wr_state_q == W_XFER) begin
      s_axi_awaddr_o  = m_axi_awaddr_i[wr_sel*ADDR_W +: ADDR_W];
      s_axi_awid_o    = m_axi_awid_i[wr_sel*ID_W +: ID_W];
      s_axi_awlen_o   = m_axi_awlen_i[wr_sel*8 +: 8];
      s_axi_awburst_o = m_axi_awburst_i[wr_sel*2 +: 2];
      s_axi_wdata_o   = m_axi_wdata_i[wr_sel*DATA_W +: DATA_W];
      s_axi_wstrb_o   = m_axi_wstrb_i[wr_sel*STRB_W +: STRB_W];
      s_axi_wlast_o   = m_axi_wlast_i[wr_owner_q];
      if (!aw_done_q) begin
        s_axi_awvalid_o             = m_axi_awvalid_i[wr_owner_q];
        m_axi_awready_o[wr_owner_q] = s_axi_awready_i;
      end
      if (!w_done_q) begin
        s_axi_wvalid_o             = m_axi_wvalid_i[wr_owner_q];
        m_axi_wready_o[wr_owner_q] = s_axi_wready_i;
      end
    end
    if (wr_state_q == W_RESP) begin
      m_axi_bvalid_o[wr_owner_q]       = s_axi_bvalid_i;
      m_axi_bresp_o[wr_sel*2 +: 2]     = s_axi_bresp_i;
      m_axi_bid_o[wr_sel*ID_W +: ID_W] = s_axi_bid_i;
      s_axi_bready_o                   = m_axi_bready_i[wr_owner_q];
    end
  end

endmodule

// File: tb/tb_riscv_axi_arb2.sv
// tb/tb_riscv_axi_arb2.sv - directed self-checking bench for riscv_axi_arb2
module tb_riscv_axi_arb2;

`ifdef RISCV_AXI_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [31:0] A0  = 32'h1000_0000;
  localparam logic [31:0] A1  = 32'h2000_0000;
  localparam logic [3:0]  ID0 = 4'h3;
  localparam logic [3:0]  ID1 = 4'h5;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [63:0] m_araddr, m_rdata;
  logic [7:0]  m_arid, m_rid;
  logic [15:0] m_arlen;
  logic [3:0]  m_arburst, m_rresp;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [63:0] m_awaddr, m_wdata;
  logic [7:0]  m_awid, m_wstrb, m_bid;
  logic [15:0] m_awlen;
  logic [3:0]  m_awburst, m_bresp;

  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [1:0]  s_arburst, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_awid, s_wstrb, s_bid;
  logic [7:0]  s_awlen;
  logic [1:0]  s_awburst, s_bresp;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  riscv_axi_arb2 dut (
    .clk_i(clk), .rst_i(rst),
    .m_axi_arvalid_i(m_arvalid), .m_axi_araddr_i(m_araddr), .m_axi_arid_i(m_arid),
    .m_axi_arlen_i(m_arlen), .m_axi_arburst_i(m_arburst), .m_axi_arready_o(m_arready),
    .m_axi_rvalid_o(m_rvalid), .m_axi_rdata_o(m_rdata), .m_axi_rresp_o(m_rresp),
    .m_axi_rid_o(m_rid), .m_axi_rlast_o(m_rlast), .m_axi_rready_i(m_rready),
    .m_axi_awvalid_i(m_awvalid), .m_axi_awaddr_i(m_awaddr), .m_axi_awid_i(m_awid),
    .m_axi_awlen_i(m_awlen), .m_axi_awburst_i(m_awburst), .m_axi_awready_o(m_awready),
    .m_axi_wvalid_i(m_wvalid), .m_axi_wdata_i(m_wdata), .m_axi_wstrb_i(m_wstrb),
    .m_axi_wlast_i(m_wlast), .m_axi_wready_o(m_wready),
    .m_axi_bvalid_o(m_bvalid), .m_axi_bresp_o(m_bresp), .m_axi_bid_o(m_bid),
    .m_axi_bready_i(m_bready),
    .s_axi_arvalid_o(s_arvalid), .s_axi_araddr_o(s_araddr), .s_axi_arid_o(s_arid),
    .s_axi_arlen_o(s_arlen), .s_axi_arburst_o(s_arburst), .s_axi_arready_i(s_arready),
    .s_axi_rvalid_i(s_rvalid), .s_axi_rdata_i(s_rdata), .s_axi_rresp_i(s_rresp),
    .s_axi_rid_i(s_rid), .s_axi_rlast_i(s_rlast), .s_axi_rready_o(s_rready),
    .s_axi_awvalid_o(s_awvalid), .s_axi_awaddr_o(s_awaddr), .s_axi_awid_o(s_awid),
    .s_axi_awlen_o(s_awlen), .s_axi_awburst_o(s_awburst), .s_axi_awready_i(s_awready),
    .s_axi_wvalid_o(s_wvalid), .s_axi_wdata_o(s_wdata), .s_axi_wstrb_o(s_wstrb),
    .s_axi_wlast_o(s_wlast), .s_axi_wready_i(s_wready),
    .s_axi_bvalid_i(s_bvalid), .s_axi_bresp_i(s_bresp), .s_axi_bid_i(s_bid),
    .s_axi_bready_o(s_bready)
  );

  typedef struct {
    logic [1:0]  arv;
    logic        arrdy;
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        rl;
    logic [1:0]  mrr;
    logic        e_arv;
    logic [31:0] e_addr;
    logic [1:0]  e_arrdy;
    logic [1:0]  e_rv;
    logic        e_rrdy;
    logic [63:0] e_rd;
    logic [3:0]  e_rr;
    logic [1:0]  e_rl;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_arvalid = '0; m_rready = '0; m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rid = '0; s_rlast = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0; s_bid = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_awvalid", s_awvalid, 0);
    chk("rst_s_wvalid",  s_wvalid, 0);
    chk("rst_m_readies", {m_arready, m_awready, m_wready}, 0);
    chk("rst_m_valids",  {m_rvalid, m_bvalid}, 0);
    chk("rst_s_readies", {s_rready, s_bready}, 0);
    chk("rst_payload",   {s_araddr, s_awaddr}, 0);
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] addr_of [2];
  int first_own;
  int exp_own;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    addr_of[0] = A0;
    addr_of[1] = A1;
    first_own = FIXED ? 1 : 0;
    m_araddr = {A1, A0}; m_arid = {ID1, ID0}; m_arburst = {2'd2, 2'd1}; m_arlen = {8'd0, 8'd1};
    m_awaddr = {A1, A0}; m_awid = {ID1, ID0}; m_awburst = {2'd2, 2'd1}; m_awlen = {8'd3, 8'd0};
    m_wdata = '0; m_wstrb = 8'hF5;
    rst = 1'b1;
    clear_inputs();

    // arv, arrdy, rv, rd, rr, rl, mrr | e_arv, e_addr, e_arrdy, e_rv, e_rrdy, e_rd, e_rr, e_rl
    tbl[0] = '{2'b01, 1'b0, 1'b0, 32'h0,    2'd0, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 64'h0, 4'b0000, 2'b00};
    tbl[1] = '{2'b01, 1'b0, 1'b0, 32'h0,    2'd0, 1'b0, 2'b00, 1'b1, A0,    2'b00, 2'b00, 1'b0, 64'h0, 4'b0000, 2'b00};
    tbl[2] = '{2'b01, 1'b1, 1'b0, 32'h0,    2'd0, 1'b0, 2'b00, 1'b1, A0,    2'b01, 2'b00, 1'b0, 64'h0, 4'b0000, 2'b00};
    tbl[3] = '{2'b00, 1'b0, 1'b1, 32'hD1D1, 2'd2, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 2'b01, 1'b0, {32'h0, 32'hD1D1}, 4'b0010, 2'b00};
    tbl[4] = '{2'b00, 1'b0, 1'b1, 32'hD1D1, 2'd2, 1'b0, 2'b01, 1'b0, 32'h0, 2'b00, 2'b01, 1'b1, {32'h0, 32'hD1D1}, 4'b0010, 2'b00};
    tbl[5] = '{2'b00, 1'b0, 1'b1, 32'hD2D2, 2'd0, 1'b1, 2'b11, 1'b0, 32'h0, 2'b00, 2'b01, 1'b1, {32'h0, 32'hD2D2}, 4'b0000, 2'b01};
    tbl[6] = '{2'b10, 1'b0, 1'b0, 32'h0,    2'd0, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 64'h0, 4'b0000, 2'b00};
    tbl[7] = '{2'b10, 1'b1, 1'b0, 32'h0,    2'd0, 1'b0, 2'b00, 1'b1, A1,    2'b10, 2'b00, 1'b0, 64'h0, 4'b0000, 2'b00};
    tbl[8] = '{2'b00, 1'b0, 1'b1, 32'hD3D3, 2'd3, 1'b1, 2'b10, 1'b0, 32'h0, 2'b00, 2'b10, 1'b1, {32'hD3D3, 32'h0}, 4'b1100, 2'b10};
    tbl[9] = '{2'b00, 1'b0, 1'b1, 32'hD3D3, 2'd3, 1'b1, 2'b11, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 64'h0, 4'b0000, 2'b00};

    // single-requester reads, SLVERR/DECERR pass-through, rready backpressure
    do_reset();
    for (int i = 0; i < 10; i++) begin
      m_arvalid = tbl[i].arv; s_arready = tbl[i].arrdy; s_rvalid = tbl[i].rv; s_rdata = tbl[i].rd;
      s_rresp = tbl[i].rr; s_rlast = tbl[i].rl; m_rready = tbl[i].mrr; s_rid = ID0;
      #1;
      chk($sformatf("t%0d_s_arvalid", i), s_arvalid, tbl[i].e_arv);
      chk($sformatf("t%0d_s_araddr", i),  s_araddr,  tbl[i].e_addr);
      chk($sformatf("t%0d_m_arready", i), m_arready, tbl[i].e_arrdy);
      chk($sformatf("t%0d_m_rvalid", i),  m_rvalid,  tbl[i].e_rv);
      chk($sformatf("t%0d_s_rready", i),  s_rready,  tbl[i].e_rrdy);
      chk($sformatf("t%0d_m_rdata", i),   m_rdata,   tbl[i].e_rd);
      chk($sformatf("t%0d_m_rresp", i),   m_rresp,   tbl[i].e_rr);
      chk($sformatf("t%0d_m_rlast", i),   m_rlast,   tbl[i].e_rl);
      tick();
    end
    clear_inputs();

    // tie after reset, 8-beat bursts to each master in turn
    do_reset();
    m_arlen = {8'd7, 8'd7};
    m_arvalid = 2'b11;
    #1;
    chk("a_idle_arvalid", s_arvalid, 0);
    tick();
    for (int n = 0; n < 2; n++) begin
      exp_own = (n == 0) ? first_own : 1 - first_own;
      s_arready = 1'b1;
      #1;
      chk("a_araddr", s_araddr, addr_of[exp_own]);
      chk("a_arlen", s_arlen, 8'd7);
      chk("a_arready", m_arready, (exp_own == 1) ? 2'b10 : 2'b01);
      tick();
      m_arvalid[exp_own] = 1'b0;
      s_arready = 1'b0;
      for (int b = 0; b < 8; b++) begin
        s_rvalid = 1'b1; s_rdata = 32'hA000 + b; s_rlast = (b == 7); m_rready = 2'b11;
        s_rid = (exp_own == 1) ? ID1 : ID0;
        #1;
        chk("a_rvalid", m_rvalid, (exp_own == 1) ? 2'b10 : 2'b01);
        chk("a_rdata", m_rdata, (exp_own == 1) ? {32'hA000 + b, 32'h0} : {32'h0, 32'hA000 + b});
        chk("a_rid", m_rid, (exp_own == 1) ? {ID1, 4'h0} : {4'h0, ID0});
        chk("a_rlast", m_rlast[exp_own], (b == 7));
        tick();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0;
      #1;
      chk("a_gap_arvalid", s_arvalid, 0);
      if (n == 0) tick();
    end
    clear_inputs();
    tick();

    // m1 write, W ahead of AW, AW accepted after two data beats
    m_wvalid = 2'b10; m_wdata = {32'hB000, 32'h0}; m_wlast = 2'b00;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("b_early_wready", m_wready, 2'b00);
      chk("b_early_swvalid", s_wvalid, 0);
      tick();
    end
    m_awvalid = 2'b10;
    #1;
    chk("b_idle_awvalid", s_awvalid, 0);
    tick();
    s_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_wdata = {32'hB000 + i, 32'h0}; m_wlast = (i == 3) ? 2'b10 : 2'b00; s_awready = (i == 2);
      #1;
      chk("b_swvalid", s_wvalid, 1);
      chk("b_swdata", s_wdata, 32'hB000 + i);
      chk("b_swstrb", s_wstrb, 4'hF);
      chk("b_swlast", s_wlast, (i == 3));
      chk("b_wready", m_wready, 2'b10);
      chk("b_sawvalid", s_awvalid, (i <= 2));
      chk("b_awready", m_awready, (i == 2) ? 2'b10 : 2'b00);
      chk("b_awaddr", s_awaddr, A1);
      chk("b_awlen", s_awlen, 8'd3);
      tick();
      if (i == 2) m_awvalid = 2'b00;
    end
    m_wvalid = 2'b00; m_wlast = 2'b00; s_wready = 1'b0; s_awready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'd0; s_bid = ID1; m_bready = 2'b11;
    #1;
    chk("b_bvalid", m_bvalid, 2'b10);
    chk("b_bresp", m_bresp, 4'b0000);
    chk("b_bid", m_bid, {ID1, 4'h0});
    chk("b_bready", s_bready, 1);
    chk("b_swvalid_resp", s_wvalid, 0);
    tick();
    s_bvalid = 1'b0;
    #1;
    chk("b_after_bvalid", m_bvalid, 2'b00);
    clear_inputs();

    // m0 read and m1 write in the same cycle
    m_arlen = {8'd0, 8'd0}; m_awlen = {8'd0, 8'd0};
    m_arvalid = 2'b01; m_awvalid = 2'b10;
    #1;
    chk("c_idle", {s_arvalid, s_awvalid}, 2'b00);
    tick();
    chk("c_both_valid", {s_arvalid, s_awvalid}, 2'b11);
    chk("c_addrs", {s_araddr, s_awaddr}, {A0, A1});
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    m_wvalid = 2'b10; m_wlast = 2'b10; m_wdata = {32'hC0C0, 32'h0};
    #1;
    chk("c_readies", {m_arready, m_awready, m_wready}, {2'b01, 2'b10, 2'b10});
    tick();
    clear_inputs();
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'hC1C1; m_rready = 2'b01;
    s_bvalid = 1'b1; s_bresp = 2'd2; s_bid = ID1; m_bready = 2'b10;
    #1;
    chk("c_rvalid", m_rvalid, 2'b01);
    chk("c_bvalid", m_bvalid, 2'b10);
    chk("c_bresp", m_bresp, 4'b1000);
    tick();
    clear_inputs();
    #1;
    chk("c_done", {s_rready, s_bready, m_rvalid, m_bvalid}, 0);

    // reset mid-burst, then a tie goes back to the reset winner
    m_arlen = {8'd7, 8'd7};
    m_arvalid = 2'b01;
    tick();
    s_arready = 1'b1;
    tick();
    m_arvalid = 2'b00; s_arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      s_rvalid = 1'b1; s_rdata = b; m_rready = 2'b01;
      tick();
    end
    s_rdata = 32'h3;
    #1;
    chk("d_beat3_rvalid", m_rvalid, 2'b01);
    rst = 1'b1;
    #1;
    chk("d_rst_rvalid", m_rvalid, 2'b00);
    chk("d_rst_rready", s_rready, 0);
    chk("d_rst_rdata", m_rdata, 0);
    chk("d_rst_arready", m_arready, 2'b00);
    tick();
    rst = 1'b0;
    clear_inputs();
    m_arvalid = 2'b11;
    tick();
    #1;
    chk("d_tie_after_rst", s_araddr, addr_of[first_own]);
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // continuous contention: alternation (or dcache always, with fixed priority)
    m_arlen = {8'd0, 8'd0};
    for (int k = 0; k < 4; k++) begin
      exp_own = FIXED ? 1 : (k % 2);
      m_arvalid = 2'b11;
      tick();
      s_arready = 1'b1;
      #1;
      chk($sformatf("e%0d_araddr", k), s_araddr, addr_of[exp_own]);
      tick();
      s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 2'b11;
      #1;
      chk($sformatf("e%0d_rvalid", k), m_rvalid, (exp_own == 1) ? 2'b10 : 2'b01);
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_axi_arb2.md
Name: riscv_axi_arb2

Overview:
- Two-master to one-slave AXI4 arbiter.
- Master 0 is the icache AXI port; master 1 is the dcache AXI port. The slave port feeds the single SoC memory/interconnect port.
- Read and write paths are arbitrated independently. Each path has its own FSM.
- One outstanding burst per path; the owning master is locked until that burst's response completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; STRB_W = DATA_W/8.
- ID_W, 4, AXI ID width; IDs pass through unchanged.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- Master-side buses are packed per master. Master n occupies slice [n*W +: W].
- m_axi_ar{valid,addr,id,len,burst}_i  in  2/2*ADDR_W/2*ID_W/16/4  read address from masters.
- m_axi_arready_o  out  2  read address accept.
- m_axi_r{valid,data,resp,id,last}_o  out  2/2*DATA_W/4/2*ID_W/2  read data to masters.
- m_axi_rready_i  in  2  read data accept.
- m_axi_aw{valid,addr,id,len,burst}_i  in  2/2*ADDR_W/2*ID_W/16/4  write address from masters.
- m_axi_awready_o  out  2  write address accept.
- m_axi_w{valid,data,strb,last}_i  in  2/2*DATA_W/2*STRB_W/2  write data from masters.
- m_axi_wready_o  out  2  write data accept.
- m_axi_b{valid,resp,id}_o  out  2/4/2*ID_W  write response to masters.
- m_axi_bready_i  in  2  write response accept.
- s_axi_ar{valid,addr,id,len,burst}_o  out  1/ADDR_W/ID_W/8/2  read address to slave.
- s_axi_arready_i  in  1  slave read address accept.
- s_axi_r{valid,data,resp,id,last}_i  in  1/DATA_W/2/ID_W/1  read data from slave.
- s_axi_rready_o  out  1  read data accept to slave.
- s_axi_aw{valid,addr,id,len,burst}_o  out  1/ADDR_W/ID_W/8/2  write address to slave.
- s_axi_awready_i  in  1  slave write address accept.
- s_axi_w{valid,data,strb,last}_o  out  1/DATA_W/STRB_W/1  write data to slave.
- s_axi_wready_i  in  1  slave write data accept.
- s_axi_b{valid,resp,id}_i  in  1/2/ID_W  write response from slave.
- s_axi_bready_o  out  1  write response accept to slave.

Behaviour:
- Reset (asynchronous, active-high):
  - All *valid_o and *ready_o outputs are 0.
  - Payload outputs are 0.
  - Both FSMs go to IDLE.
  - Both round-robin last-grant pointers are set to 1, so master 0 wins the first tie.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: if any m_arvalid is set, register the owner from the picker and go to R_ADDR. All readies are 0 in this state.
  - R_ADDR: s_ar* = m_ar*[owner] and m_arready[owner] = s_arready. On handshake, update the pointer to owner and go to R_DATA.
  - R_DATA: m_r*[owner] = s_r* and s_rready = m_rready[owner]. On a handshake with rlast = 1, return to R_IDLE.
- Write FSM: W_IDLE -> W_XFER -> W_RESP -> W_IDLE.
  - W_IDLE: arbitrates m_awvalid in the same way as R_IDLE.
  - W_XFER: the AW and W channels of the owner are forwarded concurrently. Flags aw_done and w_done (set on the wlast handshake) are set sticky. When both are set, go to W_RESP. W data may complete before AW.
  - W_RESP: B is forwarded to the owner. On handshake, return to W_IDLE.
- Non-owners always see ready = 0 and valid = 0 on every channel.
- Registered grant:
  - Slave-side payload depends only on the registered owner, so payload stays stable while valid is held (AXI compliant).
  - Arbitration latency is 1 cycle from valid to slave valid.
  - There is a minimum of 1 idle cycle between bursts on the same path.
- Read and write paths may serve different masters simultaneously. There is no ordering between them.
- A master whose valid drops in R_ADDR/W_XFER is illegal AXI and is not handled.
- Width rules:
  - len and burst pass through unchanged.
  - resp pass-through includes SLVERR/DECERR.
  - IDs pass through unchanged; routing uses the registered owner, not the ID.
- Round-robin: if both masters request, grant the master that is not the last granted. A single requester always wins immediately.
- Reset mid-burst aborts the burst. The external slave is expected to be reset by the same rst_i.

Optional Feature:
- Macro: RISCV_AXI_ARB_FIXED_PRIO_EN.
- Defined: master 1 (dcache) always wins ties on both paths. The pointers are unused.
- Undefined: round-robin as above.

Decomposition:
- Package riscv_axi_arb_pkg holds:
  - read and write FSM state typedefs and encodings;
  - AXI resp constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3).
- Sub-module riscv_axi_arb_rr2: a 2-way picker. Inputs: req[1:0] and last_grant. Output: grant index. It is combinational, and it is instantiated once for the read path and once for the write path.

Test Plan:
- Both m_arvalid = 1 after reset, with len = 7 each -> m0 is granted first. Eight beats reach m0 only, the last with rlast. Then m1 is granted and receives eight beats. m1 sees no rvalid during m0's burst.
- Only m1 writes, awlen = 3, with W presented 2 cycles before AW -> four W beats forwarded, then 1 B, bresp = 0 delivered to m1. m0 readies stay 0.
- m0 read and m1 write issued in the same cycle -> both slave channels are active in cycle +1 and complete independently.
- Slave returns rresp = 2 with s_rready backpressure (m0 rready toggles) -> resp = 2 reaches m0 unchanged. No beat is lost or duplicated.
- rst_i asserted in R_DATA after beat 3 of 8 -> all valids and readies are 0 in the same cycle. After release, master 0 wins the next tie.
- RISCV_AXI_ARB_FIXED_PRIO_EN defined, with continuous requests from both masters -> m1 is granted 3 times in a row; m0 is granted only when m1 is idle.
